// File: rtl/weight_pkg.sv
// Shared types and default sizes for the weight RAM, the LFSR and the
// weight initialisation sequencer.
package weight_pkg;

    localparam int W_WIDTH   = 10;
    localparam int N_WEIGHTS = 10;
    localparam int ADDR_W    = 7;

    typedef logic [W_WIDTH-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } init_state_t;

endpackage

// File: rtl/weight_init_ctrl.sv
// Weight RAM initialisation sequencer.
// Gathers N_WEIGHTS consecutive LFSR samples into a row, writes that row
// with a one-cycle WE pulse at row*ADDR_STEP, repeats for N_ROWS rows and
// then hands the RAM back to read mode.
// Build option: WEIGHT_SCALE_EN -- store each sample arithmetically shifted
// right by INIT_SHIFT so initial weights start small.
//
// state | meaning
// IDLE  | waiting for Start after reset
// FILL  | capturing one LFSR sample per cycle into the row buffer
// WRITE | single-cycle RAM write of the completed row
// DONE  | RAM in read mode; Start re-runs the whole sequence
module weight_init_ctrl
    import weight_pkg::*;
#(
    parameter int W_WIDTH    = weight_pkg::W_WIDTH,
    parameter int N_WEIGHTS  = weight_pkg::N_WEIGHTS,
    parameter int ADDR_W     = weight_pkg::ADDR_W,
    parameter int N_ROWS     = 5,
    parameter int ADDR_STEP  = 10,
    parameter int INIT_SHIFT = 3
) (
    input  logic               Clock,
    input  logic               Rst,
    input  logic               Start,
    input  logic [W_WIDTH-1:0] RndData,
    output logic [W_WIDTH-1:0] D1 [0:N_WEIGHTS-1],
    output logic [ADDR_W-1:0]  Address,
    output logic               WE,
    output logic               In,
    output logic               Busy,
    output logic               Done
);

    localparam int SMP_W = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(N_WEIGHTS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

`ifdef WEIGHT_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif
    // A zero shift leaves the sample untouched, so one datapath serves both builds.
    localparam int SHIFT_EFF = SCALE_ON ? INIT_SHIFT : 0;

    init_state_t        r_state;
    init_state_t        w_state_nxt;
    logic [SMP_W-1:0]   r_sample;
    logic [ROW_W-1:0]   r_row;
    logic [W_WIDTH-1:0] r_d1 [0:N_WEIGHTS-1];
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic               r_in;
    logic               r_busy;
    logic               r_done;
    logic [W_WIDTH-1:0] w_sample;

    assign w_sample = $signed(RndData) >>> SHIFT_EFF;

    // Next-state decode; Start is only looked at while idle or finished.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (Start) w_state_nxt = FILL;
            FILL:       if (r_sample == LAST_SMP) w_state_nxt = WRITE;
            WRITE:      w_state_nxt = (r_row == LAST_ROW) ? DONE : FILL;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (!Rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Row buffer, counters and registered outputs, all decoded from the next state
    // so every output changes on the same edge as the state it belongs to.
    always_ff @(posedge Clock) begin
        if (!Rst) begin
            for (int i = 0; i < N_WEIGHTS; i++) r_d1[i] <= '0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_in     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sample <= '0;
            r_row    <= '0;
        end else begin
            r_we   <= (w_state_nxt == WRITE);
            r_busy <= (w_state_nxt == FILL) || (w_state_nxt == WRITE);
            r_done <= (w_state_nxt == DONE);
            r_in   <= (w_state_nxt != DONE);
            case (r_state)
                IDLE, DONE: begin
                    if (Start) begin
                        r_row    <= '0;
                        r_sample <= '0;
                    end
                end
                FILL: begin
                    r_d1[r_sample] <= w_sample;
                    if (r_sample == LAST_SMP) begin
                        r_sample <= '0;
                        r_addr   <= ADDR_W'(int'(r_row) * ADDR_STEP);
                    end else begin
                        r_sample <= r_sample + 1'b1;
                    end
                end
                WRITE: begin
                    if (r_row != LAST_ROW) r_row <= r_row + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign D1      = r_d1;
    assign Address = r_addr;
    assign WE      = r_we;
    assign In      = r_in;
    assign Busy    = r_busy;
    assign Done    = r_done;

endmodule

// File: doc/weight_init_ctrl.md
Name: weight_init_ctrl

Overview:
- Upstream sequencer for the weight RAM: fills the RAM with pseudo-random initial weights at power-up or on request.
- Collects N_WEIGHTS consecutive 10-bit samples from the LFSR into one row, then issues a single-cycle write of that row at Address = row*ADDR_STEP.
- Repeats for N_ROWS rows, then hands the RAM over to read mode (In=0) and raises Done.

Parameters:
- W_WIDTH, 10, bits per weight and per LFSR sample
- N_WEIGHTS, 10, weights per RAM row (width of the D1 array)
- ADDR_W, 7, RAM address width
- N_ROWS, 5, rows to initialise
- ADDR_STEP, 10, address increment per row; N_ROWS*ADDR_STEP must be at most 2^ADDR_W
- INIT_SHIFT, 3, arithmetic right-shift applied when WEIGHT_SCALE_EN is defined

Ports:
- Clock  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-low reset
- Start  in  1  level request to (re)initialise; sampled in IDLE and DONE
- RndData  in  W_WIDTH  LFSR output, new value every cycle
- D1  out  N_WEIGHTS x W_WIDTH  row data to RAM (unpacked array [0:N_WEIGHTS-1])
- Address  out  ADDR_W  RAM row address
- WE  out  1  RAM write enable, one-cycle pulse per row
- In  out  1  RAM mode select: 1 = init/write mode, 0 = read mode
- Busy  out  1  high in FILL and WRITE
- Done  out  1  high in DONE

Behaviour:
- Reset (Rst=0 at a rising edge):
  - State goes to IDLE.
  - D1 all zero, Address=0, WE=0, In=1, Busy=0, Done=0.
  - Row and sample counters are cleared.
  - Reset mid-operation aborts the operation; a partially filled row is discarded and never written.
- FSM states: IDLE, FILL, WRITE, DONE. All outputs are registered.
- IDLE:
  - Start=1 sampled at edge k moves the FSM to FILL.
  - Row counter is set to 0 and sample counter to 0.
- FILL:
  - At each edge, D1[sample] <= RndData, then sample++.
  - The sample taken with sample==N_WEIGHTS-1 moves the FSM to WRITE.
  - First row: samples are taken at edges k+1 through k+10.
- WRITE:
  - Lasts exactly one cycle, with WE=1 and Address=row*ADDR_STEP.
  - D1 holds stable for the whole cycle.
  - Exit when row==N_ROWS-1: go to DONE.
  - Otherwise: row++, sample=0, go to FILL.
- Timing:
  - Each row takes N_WEIGHTS+1 = 11 cycles.
  - The first WE is high in the cycle after edge k+10.
  - Done rises 55 cycles after Start was sampled (default parameters).
- DONE:
  - In=0 and Done=1; WE stays 0; D1 and Address hold their last values.
  - Start=1 sampled in DONE restarts initialisation exactly as from IDLE; In returns to 1.
- Start is ignored while Busy. Holding Start high through DONE causes an immediate restart, so the testbench must drop Start.
- Address arithmetic:
  - Computed as row*ADDR_STEP, truncated to ADDR_W bits.
  - With default parameters the written addresses are 0, 10, 20, 30, 40.
- WE is never high for two consecutive cycles and is never high outside WRITE.

Optional Feature:
- Macro: WEIGHT_SCALE_EN.
- When defined, each stored sample is RndData arithmetically shifted right by INIT_SHIFT (sign bit replicated), which keeps initial weights small.
  - Example: 10'b1000000000 is stored as 10'b1111000000.
- When undefined, RndData is stored unmodified.
- Timing is identical in both builds.

Decomposition:
- Package weight_pkg holds:
  - W_WIDTH, N_WEIGHTS, ADDR_W defaults;
  - typedef weight_t (logic [W_WIDTH-1:0]);
  - typedef enum init_state_t {IDLE, FILL, WRITE, DONE}.
- The same package is shared with the weight RAM and the LFSR.
- No sub-module: the LFSR is instantiated beside this block at the top level, not inside it.

Test Plan:
- Reset: hold Rst=0 for 10 cycles -> D1 all 0, Address=0, WE=0, In=1, Busy=0, Done=0.
- Full init, with RndData driven as a counter 1,2,3,… from Start:
  - Row 0: WE pulse 11 cycles after Start with Address=0 and D1=1..10.
  - Row 1: Address=10, D1=11..20.
  - Last row: Address=40.
  - Done=1 and In=0 at cycle 55; exactly 5 WE pulses in total.
- Start re-pulsed at cycle 20 (while Busy) -> ignored; address and WE sequence unchanged.
- Rst=0 at cycle 30 (mid row 2) -> IDLE, WE=0, no write to address 20 afterwards. A new Start gives a full sequence again from Address=0.
- Restart from DONE: Start=1 after Done -> In=1, Done=0, then 5 new WE pulses at addresses 0, 10, 20, 30, 40.
- With WEIGHT_SCALE_EN defined: RndData=10'h200 -> stored 10'h3C0; RndData=10'h0F8 -> stored 10'h01F.
